// File: rtl/lc3_decode.sv
// LC-3 style fetch/decode controller: sequences memory wait, instruction latch and issue,
// and tracks condition codes. Define DECODE_ILLEGAL_TRAP_EN to trap opcode 4'b1101 into HALT.
module lc3_decode #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_in,
    input  logic [15:0] instr_in,
    input  logic        wb_valid_in,
    input  logic [15:0] wb_value_in,
    output logic        fetch_start,
    output logic [3:0]  opCode_out,
    output logic [8:0]  offset_out,
    output logic [2:0]  br_nzp,
    output logic [2:0]  result_nzp,
    output logic [15:0] ir_out,
`ifdef DECODE_ILLEGAL_TRAP_EN
    output logic        illegal_out,
`endif
    output logic        busy_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MEM,
        S_LATCH,
        S_ISSUE
`ifdef DECODE_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);
    localparam logic [3:0] OP_ILLEGAL = 4'hD;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_cnt;
    logic [15:0]        r_ir;
    logic [2:0]         r_nzp;

    function automatic logic [2:0] nzp_of(input logic signed [15:0] v);
        if (v < 0)
            return 3'b100;
        else if (v == 0)
            return 3'b010;
        else
            return 3'b001;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (run_in) w_next = S_WAIT_MEM;
            S_WAIT_MEM: if (r_cnt == 3'd0) w_next = S_LATCH;
            S_LATCH: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                if (instr_in[15:12] == OP_ILLEGAL)
                    w_next = S_HALT;
                else
`endif
                    w_next = S_ISSUE;
            end
            // run_in is only consulted here, so an instruction in flight always completes
            S_ISSUE:    w_next = run_in ? S_WAIT_MEM : S_IDLE;
`ifdef DECODE_ILLEGAL_TRAP_EN
            S_HALT:     w_next = S_HALT;
`endif
            default:    w_next = S_IDLE;
        endcase
    end

    // Latency counter: loaded on entry to WAIT_MEM so the wait lasts MEM_LAT cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= 3'd0;
        else if (w_next == S_WAIT_MEM && r_state != S_WAIT_MEM)
            r_cnt <= LAT_M1;
        else if (r_state == S_WAIT_MEM && r_cnt != 3'd0)
            r_cnt <= r_cnt - 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ir <= 16'h0000;
        else if (r_state == S_LATCH)
            r_ir <= instr_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_nzp <= 3'b010;
        else if (wb_valid_in)
            r_nzp <= nzp_of(wb_value_in);
    end

    assign fetch_start = (r_state == S_ISSUE);
    assign busy_out    = (r_state != S_IDLE);
    assign ir_out      = r_ir;
    assign offset_out  = r_ir[8:0];
    assign result_nzp  = r_nzp;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign opCode_out  = r_ir[15:12];
    assign br_nzp      = r_ir[11:9];
    // HALT is only left through reset, so the state itself is the sticky flag
    assign illegal_out = (r_state == S_HALT);
`else
    logic w_illegal_op;
    // Opcode 1101 degrades to a never-taken branch
    assign w_illegal_op = (r_ir[15:12] == OP_ILLEGAL);
    assign opCode_out   = w_illegal_op ? 4'h0 : r_ir[15:12];
    assign br_nzp       = w_illegal_op ? 3'b000 : r_ir[11:9];
`endif

endmodule

// File: tb/tb_lc3_decode.sv
// Scoreboard bench for lc3_decode: expected issue events are queued when an instruction
// is started and compared when fetch_start pulses.
module tb_lc3_decode;
    localparam int MEM_LAT = 2;
    localparam int ISS_LAT = MEM_LAT + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_in;
    logic [15:0] instr_in;
    logic        wb_valid_in;
    logic [15:0] wb_value_in;
    logic        fetch_start;
    logic [3:0]  opCode_out;
    logic [8:0]  offset_out;
    logic [2:0]  br_nzp;
    logic [2:0]  result_nzp;
    logic [15:0] ir_out;
    logic        busy_out;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic        illegal_out;
`endif

    lc3_decode #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .run_in(run_in),
        .instr_in(instr_in),
        .wb_valid_in(wb_valid_in),
        .wb_value_in(wb_value_in),
        .fetch_start(fetch_start),
        .opCode_out(opCode_out),
        .offset_out(offset_out),
        .br_nzp(br_nzp),
        .result_nzp(result_nzp),
        .ir_out(ir_out),
`ifdef DECODE_ILLEGAL_TRAP_EN
        .illegal_out(illegal_out),
`endif
        .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         cyc;
        logic [3:0] op;
        logic [2:0] br;
        logic [8:0] off;
        logic [2:0] nzp;
    } exp_t;
    exp_t sb[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int c, input logic [3:0] op, input logic [2:0] br,
                            input logic [8:0] off, input logic [2:0] nzp);
        exp_t e;
        e.cyc = c; e.op = op; e.br = br; e.off = off; e.nzp = nzp;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (fetch_start === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_pulse", 32'(fetch_start), 32'(0));
            end else begin
                e = sb.pop_front();
                check_val("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check_val("pulse_op", 32'(opCode_out), 32'(e.op));
                check_val("pulse_br", 32'(br_nzp), 32'(e.br));
                check_val("pulse_off", 32'(offset_out), 32'(e.off));
                check_val("pulse_nzp", 32'(result_nzp), 32'(e.nzp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, sb=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outs(input string tag);
        check_val({tag, "_fetch"}, 32'(fetch_start), 32'(0));
        check_val({tag, "_busy"}, 32'(busy_out), 32'(0));
        check_val({tag, "_ir"}, 32'(ir_out), 32'(0));
        check_val({tag, "_op"}, 32'(opCode_out), 32'(0));
        check_val({tag, "_br"}, 32'(br_nzp), 32'(0));
        check_val({tag, "_off"}, 32'(offset_out), 32'(0));
        check_val({tag, "_nzp"}, 32'(result_nzp), 32'(3'b010));
`ifdef DECODE_ILLEGAL_TRAP_EN
        check_val({tag, "_ill"}, 32'(illegal_out), 32'(0));
`endif
    endtask

    logic [15:0] wb_tbl [6] = '{16'h8000, 16'h0000, 16'h0007, 16'h7FFF, 16'hFFFF, 16'h0001};
    logic [2:0]  nzp_tbl[6] = '{3'b100, 3'b010, 3'b001, 3'b001, 3'b100, 3'b001};
    logic [15:0] ins_tbl[3] = '{16'h1E3F, 16'hB1FF, 16'h5A2C};
    logic [3:0]  op_tbl [3] = '{4'h1, 4'hB, 4'h5};
    logic [2:0]  br_tbl [3] = '{3'b111, 3'b000, 3'b101};
    logic [8:0]  off_tbl[3] = '{9'h03F, 9'h1FF, 9'h02C};

    initial begin
        int k;
        rst = 1'b1; run_in = 1'b0; instr_in = 16'h0000;
        wb_valid_in = 1'b0; wb_value_in = 16'h0000;

        // reset held 5 cycles, then released idle
        step(5);
        check_reset_outs("in_rst");
        rst = 1'b0;
        step(1);
        check_reset_outs("post_rst");

        // condition codes
        for (int i = 0; i < 6; i++) begin
            wb_valid_in = 1'b1; wb_value_in = wb_tbl[i];
            step(1);
            wb_valid_in = 1'b0;
            check_val($sformatf("nzp_%0d", i), 32'(result_nzp), 32'(nzp_tbl[i]));
        end
        wb_value_in = 16'h8000;
        step(1);
        check_val("nzp_no_strobe", 32'(result_nzp), 32'(3'b001));

        // single instruction, run_in dropped mid-instruction
        instr_in = 16'h0A05;
        k = cyc; run_in = 1'b1;
        push_exp(k + ISS_LAT, 4'h0, 3'b101, 9'h005, 3'b001);
        step(1);
        run_in = 1'b0;
        step(ISS_LAT + 2);
        check_val("single_idle_busy", 32'(busy_out), 32'(0));
        check_val("single_drained", 32'(sb.size()), 32'(0));
        check_val("single_ir", 32'(ir_out), 32'(16'h0A05));
        check_val("single_hold_br", 32'(br_nzp), 32'(3'b101));

        // three back-to-back instructions; writeback in the last ISSUE cycle
        k = cyc; run_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            instr_in = ins_tbl[i];
            push_exp(k + ISS_LAT * (i + 1), op_tbl[i], br_tbl[i], off_tbl[i], 3'b001);
            while (cyc < k + ISS_LAT * (i + 1)) step(1);
        end
        run_in = 1'b0;
        wb_valid_in = 1'b1; wb_value_in = 16'h8000;
        step(1);
        wb_valid_in = 1'b0;
        check_val("nzp_after_issue", 32'(result_nzp), 32'(3'b100));
        step(3);
        check_val("burst_idle_busy", 32'(busy_out), 32'(0));
        check_val("burst_hold_op", 32'(opCode_out), 32'(4'h5));
        check_val("burst_hold_off", 32'(offset_out), 32'(9'h02C));

        // reset during WAIT_MEM, then restart
        instr_in = 16'h3C81;
        run_in = 1'b1;
        step(2);
        check_val("wait_busy", 32'(busy_out), 32'(1));
        rst = 1'b1;
        #1;
        check_reset_outs("async_rst");
        step(2);
        rst = 1'b0;
        k = cyc;
        push_exp(k + ISS_LAT, 4'h3, 3'b110, 9'h081, 3'b010);
        step(1);
        run_in = 1'b0;
        step(ISS_LAT + 3);
        check_val("restart_drained", 32'(sb.size()), 32'(0));

        // opcode 1101
        instr_in = 16'hD000;
        k = cyc; run_in = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        step(1);
        run_in = 1'b0;
        step(ISS_LAT + 2);
        check_val("halt_illegal", 32'(illegal_out), 32'(1));
        check_val("halt_busy", 32'(busy_out), 32'(1));
        check_val("halt_ir", 32'(ir_out), 32'(16'hD000));
        run_in = 1'b1;
        step(ISS_LAT + 2);
        check_val("halt_stays", 32'(busy_out), 32'(1));
        rst = 1'b1;
        #1;
        check_val("halt_rst_ill", 32'(illegal_out), 32'(0));
        check_val("halt_rst_busy", 32'(busy_out), 32'(0));
        run_in = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);
`else
        push_exp(k + ISS_LAT, 4'h0, 3'b000, 9'h000, 3'b010);
        step(1);
        run_in = 1'b0;
        step(ISS_LAT + 2);
        check_val("d000_busy", 32'(busy_out), 32'(0));
        check_val("d000_ir", 32'(ir_out), 32'(16'hD000));
        check_val("d000_op", 32'(opCode_out), 32'(0));
        check_val("d000_br", 32'(br_nzp), 32'(0));
`endif

        step(4);
        check_val("sb_drain", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lc3_decode.md
LC3_DECODE -- requirements
Module: lc3_decode

Interface
REQ-001 Parameter MEM_LAT, default 2: instruction-memory read latency in cycles, legal range 1..7.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 run_in  in  1  level; while high, decoder keeps fetching and decoding.
REQ-005 instr_in  in  16  instruction word from memory, valid MEM_LAT cycles after a read is issued.
REQ-006 wb_valid_in  in  1  writeback strobe; its value updates condition codes.
REQ-007 wb_value_in  in  16  writeback value, two's complement.
REQ-008 fetch_start  out  1  one-cycle pulse telling fetch to compute next pc.
REQ-009 opCode_out  out  4  instruction bits [15:12].
REQ-010 offset_out  out  9  instruction bits [8:0].
REQ-011 br_nzp  out  3  instruction bits [11:9] (BR condition mask).
REQ-012 result_nzp  out  3  current condition-code register.
REQ-013 ir_out  out  16  latched instruction register.
REQ-014 busy_out  out  1  high in any state other than IDLE.
REQ-015 illegal_out  out  1  sticky illegal-opcode flag; present only with the configuration macro.

Function
REQ-016 FSM states: IDLE, WAIT_MEM, LATCH, ISSUE, HALT; one state per cycle, except WAIT_MEM.
REQ-017 IDLE -> WAIT_MEM when run_in=1; otherwise stay in IDLE.
REQ-018 WAIT_MEM: 3-bit counter loads MEM_LAT-1 on entry and decrements each cycle; go to LATCH when it reads 0.
REQ-019 LATCH: ir_out <= instr_in; go to ISSUE.
REQ-020 ISSUE: fetch_start=1 for exactly this cycle; opCode_out/offset_out/br_nzp reflect ir_out from ISSUE onward and hold until the next LATCH.
REQ-021 ISSUE -> WAIT_MEM if run_in=1, else -> IDLE; a full instruction cycle takes MEM_LAT+2 cycles.
REQ-022 run_in deasserting mid-instruction does not abort it; the decoder completes through ISSUE and then goes to IDLE.
REQ-023 Condition-code update on wb_valid_in=1: result_nzp <= 3'b100 if wb_value_in[15]=1, 3'b010 if wb_value_in=0, else 3'b001; visible the next cycle.
REQ-024 Condition codes update in any state, including HALT.
REQ-025 wb_valid_in in the same cycle as ISSUE: fetch samples the old result_nzp, and the new value applies from the next cycle.
REQ-026 fetch_start is never asserted in IDLE, WAIT_MEM, LATCH or HALT.

Reset
REQ-027 rst=1 immediately forces state IDLE, counter 0, ir_out 16'h0000 and result_nzp 3'b010, independent of clk.
REQ-028 Under rst, all field outputs read 0, and fetch_start, busy_out and illegal_out read 0.
REQ-029 Reset asserted mid-operation abandons the instruction with no fetch_start pulse; operation restarts from IDLE after release.

Configuration
REQ-030 Macro DECODE_ILLEGAL_TRAP_EN, when defined: opcode 4'b1101 latched in LATCH goes LATCH -> HALT instead of ISSUE, with no fetch_start and illegal_out=1.
REQ-031 With the macro defined, HALT is left only via rst.
REQ-032 Without the macro: opcode 1101 is issued with opCode_out=4'b0000 and br_nzp=3'b000 (never-taken branch), the HALT state is absent, and illegal_out is absent.

Verification
REQ-033 rst high 5 cycles, then released with run_in=0 -> all outputs 0 except result_nzp=3'b010; busy_out=0.
REQ-034 MEM_LAT=2, run_in=1, instr_in=16'h0A05 -> fetch_start pulses on cycle 4 after run_in, with opCode_out=0, br_nzp=3'b101, offset_out=9'h005.
REQ-035 wb_valid_in pulses with values 16'h8000, 16'h0000, 16'h0007 -> result_nzp is 100, 010, 001 on the following cycles.
REQ-036 run_in held high for 3 instructions -> fetch_start pulses exactly every 4 cycles.
REQ-037 rst asserted during WAIT_MEM -> no fetch_start and state IDLE; after release with run_in=1, normal issue follows.
REQ-038 instr_in=16'hD000 -> with DECODE_ILLEGAL_TRAP_EN: illegal_out=1, busy_out stays 1, no pulse; without it: pulse with opCode_out=0 and br_nzp=000.
